// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//  Shared definitions for the fetch stage: datapath width, the bubble
//  instruction, fetch sequencer states, the IF/ID bundle and the fetch
//  address legality check.
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0,x0,0 -- canonical bubble
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
    logic            fault;
  } if_id_t;

  // A fetch faults when the PC is not word aligned or lies beyond the memory
  function automatic logic pc_faults(input logic [XLEN-1:0] pc,
                                     input int unsigned     mem_words);
    logic [XLEN-1:0] word_idx;
    word_idx = {2'b00, pc[XLEN-1:2]};
    return (pc[1:0] != 2'b00) || (word_idx >= XLEN'(mem_words));
  endfunction

endpackage

// File: rtl/instruction_fetch_ctrl_if_id_reg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_ctrl_if_id_reg
//  IF/ID pipeline register. Priority: flush > stall (hold) > load > bubble.
//  Without stall or load, decode has consumed the entry, so it turns into a
//  bubble (valid=0) while keeping the last PC.
// Ports
//  clk, rst_n   clock, async active-low reset
//  i_flush      kill entry (insert bubble)
//  i_stall      hold entry
//  i_load       load i_data
//  i_data       incoming {pc, instr, valid, fault}
//  o_data       registered IF/ID contents
// -----------------------------------------------------------------------------
module instruction_fetch_ctrl_if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_WORD = 32'h0000_0013
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_flush,
  input  logic   i_stall,
  input  logic   i_load,
  input  if_id_t i_data,
  output if_id_t o_data
);

  if_id_t r_q;

  // IF/ID entry update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '{pc: '0, instr: NOP_WORD, valid: 1'b0, fault: 1'b0};
    end else if (i_flush) begin
      r_q <= '{pc: r_q.pc, instr: NOP_WORD, valid: 1'b0, fault: 1'b0};
    end else if (!i_stall) begin
      if (i_load) begin
        r_q <= i_data;
      end else begin
        r_q <= '{pc: r_q.pc, instr: NOP_WORD, valid: 1'b0, fault: 1'b0};
      end
    end
  end

  assign o_data = r_q;

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instruction_fetch_ctrl
//  Fetch-stage sequencer: owns the PC, fetches words from instruction memory
//  over a req/valid handshake, and fills the IF/ID register. Handles stalls
//  (response parked in a one-entry buffer), EX redirects (in-flight response
//  discarded) and flushes. Illegal PCs produce a faulting NOP without a
//  memory request.
// Ports
//  clk, rst_n    clock, async active-low reset
//  imem_req      fetch request, held until imem_valid
//  imem_addr     byte address of the fetch
//  imem_rdata    fetched word, sampled with imem_valid
//  imem_valid    one-cycle response strobe
//  stall         hold PC and IF/ID
//  flush         bubble the IF/ID entry
//  redirect_en   take redirect_pc as the next fetch PC
//  redirect_pc   branch/jump target
//  if_id_pc      PC of the IF/ID entry
//  if_id_instr   instruction of the IF/ID entry
//  if_id_valid   IF/ID holds a real instruction
//  fetch_fault   IF/ID entry came from an illegal PC
// -----------------------------------------------------------------------------
module instruction_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          imem_req,
  output logic [pipeline_pkg::XLEN-1:0] imem_addr,
  input  logic [pipeline_pkg::XLEN-1:0] imem_rdata,
  input  logic                          imem_valid,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          redirect_en,
  input  logic [pipeline_pkg::XLEN-1:0] redirect_pc,
  output logic [pipeline_pkg::XLEN-1:0] if_id_pc,
  output logic [pipeline_pkg::XLEN-1:0] if_id_instr,
  output logic                          if_id_valid,
  output logic                          fetch_fault
);

  import pipeline_pkg::*;

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_imem_req;
  logic [XLEN-1:0] r_imem_addr;
  logic            r_discard;
  logic [XLEN-1:0] r_buf_instr;
  logic            r_buf_fault;

  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_discard_nxt;
  logic            w_pc_fault;
  logic            w_nxt_fault;
  logic            w_rsp;
  logic [XLEN-1:0] w_rsp_instr;
  logic            w_rsp_fault;
  logic            w_buf_ld;
  logic            w_ifid_load;
  if_id_t          w_ifid_data;
  if_id_t          w_ifid_q;

  // Next-state, PC, discard, buffer and IF/ID load decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_discard_nxt = r_discard;
    w_pc_fault    = pc_faults(r_pc, MEM_WORDS);
    w_rsp         = 1'b0;
    w_rsp_instr   = imem_rdata;
    w_rsp_fault   = 1'b0;
    w_buf_ld      = 1'b0;
    w_ifid_load   = 1'b0;
    w_ifid_data   = '{pc: r_pc, instr: imem_rdata, valid: 1'b1, fault: 1'b0};

    unique case (r_state)
      S_BOOT: w_state_nxt = S_REQ;
      S_REQ: begin
        // Illegal PC: synthesize an immediate faulting NOP response
        if (w_pc_fault) begin
          w_rsp       = 1'b1;
          w_rsp_instr = NOP_INSTR;
          w_rsp_fault = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_valid) begin
          if (r_discard) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = S_REQ;
          end else begin
            w_rsp = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          w_ifid_load = 1'b1;
          w_ifid_data = '{pc: r_pc, instr: r_buf_instr, valid: 1'b1, fault: r_buf_fault};
          w_pc_nxt    = r_pc + XLEN'(4);
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase

    // Deliver a response straight to IF/ID, or park it while stalled
    if (w_rsp) begin
      if (!stall) begin
        w_ifid_load = 1'b1;
        w_ifid_data = '{pc: r_pc, instr: w_rsp_instr, valid: 1'b1, fault: w_rsp_fault};
        w_pc_nxt    = r_pc + XLEN'(4);
        w_state_nxt = S_REQ;
      end else begin
        w_buf_ld    = 1'b1;
        w_state_nxt = S_HOLD;
      end
    end

    // Redirect overrides any delivery; an in-flight fetch is let finish and dropped
    if (redirect_en) begin
      w_pc_nxt    = redirect_pc;
      w_ifid_load = 1'b0;
      w_buf_ld    = 1'b0;
      unique case (r_state)
        S_REQ: begin
          if (w_pc_fault) begin
            w_state_nxt = S_REQ;
          end else begin
            // request is already on the bus this cycle
            w_discard_nxt = 1'b1;
            w_state_nxt   = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_valid) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = S_REQ;
          end else begin
            w_discard_nxt = 1'b1;
            w_state_nxt   = S_WAIT;
          end
        end
        default: w_state_nxt = S_REQ;
      endcase
    end

    w_nxt_fault = pc_faults(w_pc_nxt, MEM_WORDS);
  end

  // Sequencer state; the request is registered so it is already up in REQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_PC;
      r_discard   <= 1'b0;
      r_buf_instr <= NOP_INSTR;
      r_buf_fault <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_discard <= w_discard_nxt;
      if (w_buf_ld) begin
        r_buf_instr <= w_rsp_instr;
        r_buf_fault <= w_rsp_fault;
      end
      r_imem_req <= (w_state_nxt == S_WAIT) ||
                    ((w_state_nxt == S_REQ) && !w_nxt_fault);
      if (w_state_nxt == S_REQ) begin
        r_imem_addr <= w_pc_nxt;
      end
    end
  end

  instruction_fetch_ctrl_if_id_reg #(
    .NOP_WORD (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_stall (stall),
    .i_load  (w_ifid_load),
    .i_data  (w_ifid_data),
    .o_data  (w_ifid_q)
  );

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign if_id_pc    = w_ifid_q.pc;
  assign if_id_instr = w_ifid_q.instr;
  assign if_id_valid = w_ifid_q.valid;
  assign fetch_fault = w_ifid_q.fault;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_ctrl
//  Directed bench for the fetch sequencer with a latency-programmable
//  instruction memory model. Cycle indices count falling edges after reset
//  release; expected values are hand-derived for each scenario.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        flush;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fetch_fault;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instruction_fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .stall       (stall),
    .flush       (flush),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Instruction memory: accepts a request seen mid-cycle, answers mem_lat edges later
  logic [31:0] mem [0:255];
  int          mem_lat = 1;
  bit          busy    = 1'b0;
  int          cnt     = 0;
  logic [31:0] lat_addr;

  initial begin
    imem_valid = 1'b0;
    imem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[0]  = 32'h00C0_2083;
    mem[1]  = 32'h0040_2103;
    mem[2]  = 32'h0640_2183;
    mem[3]  = 32'h0030_8233;
    mem[4]  = 32'h00A0_0293;
    mem[12] = 32'h0010_0313;
  end

  always @(negedge clk) begin
    imem_valid = 1'b0;
    if (busy) begin
      if (cnt <= 1) begin
        imem_valid = 1'b1;
        imem_rdata = mem[lat_addr[9:2]];
        busy       = 1'b0;
      end else begin
        cnt--;
      end
    end else if (imem_req === 1'b1) begin
      busy     = 1'b1;
      cnt      = mem_lat;
      lat_addr = imem_addr;
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Hold reset long enough for any in-flight memory response to drain
  task automatic do_reset(input int lat);
    rst_n       = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    repeat (4) @(negedge clk);
    mem_lat = lat;
    rst_n   = 1'b1;
    cyc     = 0;
  endtask

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    repeat (3) @(negedge clk);
    check("rst_req",   32'(imem_req),    32'd0);
    check("rst_addr",  imem_addr,        32'h0);
    check("rst_pc",    if_id_pc,         32'h0);
    check("rst_instr", if_id_instr,      NOP);
    check("rst_valid", 32'(if_id_valid), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);

    // 1: streaming at one-cycle latency, one instruction every 2 cycles
    do_reset(1);
    run_to(1);
    check("t1_req0",    32'(imem_req),    32'd1);
    check("t1_addr0",   imem_addr,        32'h0);
    run_to(3);
    check("t1_pc0",     if_id_pc,         32'h0);
    check("t1_instr0",  if_id_instr,      32'h00C0_2083);
    check("t1_valid0",  32'(if_id_valid), 32'd1);
    run_to(4);
    check("t1_bubble",  32'(if_id_valid), 32'd0);
    run_to(5);
    check("t1_pc4",     if_id_pc,         32'h4);
    check("t1_instr4",  if_id_instr,      32'h0040_2103);
    run_to(7);
    check("t1_pc8",     if_id_pc,         32'h8);
    check("t1_instr8",  if_id_instr,      32'h0640_2183);
    run_to(9);
    check("t1_pcc",     if_id_pc,         32'hC);
    check("t1_instrc",  if_id_instr,      32'h0030_8233);
    check("t1_faultc",  32'(fetch_fault), 32'd0);

    // 2: stall while the pc=8 response arrives
    do_reset(1);
    run_to(6);
    stall = 1'b1;
    run_to(7);
    check("t2_hold_pc",  if_id_pc,        32'h4);
    check("t2_hold_req", 32'(imem_req),   32'd0);
    run_to(8);
    check("t2_hold_pc2", if_id_pc,        32'h4);
    check("t2_hold_rq2", 32'(imem_req),   32'd0);
    run_to(9);
    stall = 1'b0;
    check("t2_hold_rq3", 32'(imem_req),   32'd0);
    run_to(10);
    check("t2_pc8",      if_id_pc,         32'h8);
    check("t2_instr8",   if_id_instr,      32'h0640_2183);
    check("t2_valid8",   32'(if_id_valid), 32'd1);
    check("t2_next_req", 32'(imem_req),    32'd1);
    check("t2_next_adr", imem_addr,        32'hC);

    // 3: redirect while waiting on pc=0xC (latency 3)
    do_reset(3);
    run_to(14);
    redirect_en = 1'b1;
    redirect_pc = 32'h30;
    run_to(15);
    redirect_en = 1'b0;
    check("t3_addr_held", imem_addr,       32'hC);
    check("t3_req_held",  32'(imem_req),   32'd1);
    run_to(17);
    check("t3_req30",     32'(imem_req),   32'd1);
    check("t3_addr30",    imem_addr,       32'h30);
    check("t3_dropped",   32'(if_id_valid), 32'd0);
    check("t3_pc_kept",   if_id_pc,        32'h8);
    run_to(21);
    check("t3_pc30",      if_id_pc,        32'h30);
    check("t3_instr30",   if_id_instr,     32'h0010_0313);
    check("t3_valid30",   32'(if_id_valid), 32'd1);

    // 4: flush and stall together as data arrives
    do_reset(1);
    run_to(2);
    stall = 1'b1;
    flush = 1'b1;
    run_to(3);
    stall = 1'b0;
    flush = 1'b0;
    check("t4_instr",  if_id_instr,      NOP);
    check("t4_valid",  32'(if_id_valid), 32'd0);
    check("t4_fault",  32'(fetch_fault), 32'd0);
    check("t4_noreq",  32'(imem_req),    32'd0);
    run_to(4);
    check("t4_buf_pc",    if_id_pc,      32'h0);
    check("t4_buf_instr", if_id_instr,   32'h00C0_2083);
    check("t4_buf_valid", 32'(if_id_valid), 32'd1);
    check("t4_next_addr", imem_addr,     32'h4);

    // 5: misaligned and out-of-range redirect targets
    do_reset(1);
    run_to(2);
    redirect_en = 1'b1;
    redirect_pc = 32'h402;
    run_to(3);
    redirect_en = 1'b0;
    check("t5_noreq_mis", 32'(imem_req),    32'd0);
    run_to(4);
    check("t5_pc_mis",    if_id_pc,         32'h402);
    check("t5_ins_mis",   if_id_instr,      NOP);
    check("t5_flt_mis",   32'(fetch_fault), 32'd1);
    check("t5_val_mis",   32'(if_id_valid), 32'd1);
    check("t5_req_mis",   32'(imem_req),    32'd0);
    redirect_en = 1'b1;
    redirect_pc = 32'h400;
    run_to(5);
    redirect_en = 1'b0;
    check("t5_gap_valid", 32'(if_id_valid), 32'd0);
    check("t5_noreq_oor", 32'(imem_req),    32'd0);
    run_to(6);
    check("t5_pc_oor",    if_id_pc,         32'h400);
    check("t5_ins_oor",   if_id_instr,      NOP);
    check("t5_flt_oor",   32'(fetch_fault), 32'd1);
    check("t5_val_oor",   32'(if_id_valid), 32'd1);
    redirect_en = 1'b1;
    redirect_pc = 32'h10;
    run_to(7);
    redirect_en = 1'b0;
    check("t5_req_ok",    32'(imem_req),    32'd1);
    check("t5_addr_ok",   imem_addr,        32'h10);
    run_to(9);
    check("t5_pc_ok",     if_id_pc,         32'h10);
    check("t5_ins_ok",    if_id_instr,      32'h00A0_0293);
    check("t5_flt_ok",    32'(fetch_fault), 32'd0);

    // 6: reset asserted mid-fetch, stale response afterwards
    do_reset(3);
    run_to(10);
    check("t6_pre_req",  32'(imem_req),    32'd1);
    check("t6_pre_addr", imem_addr,        32'h8);
    check("t6_pre_pc",   if_id_pc,         32'h4);
    rst_n = 1'b0;
    #1;
    check("t6_rst_req",   32'(imem_req),    32'd0);
    check("t6_rst_addr",  imem_addr,        32'h0);
    check("t6_rst_pc",    if_id_pc,         32'h0);
    check("t6_rst_instr", if_id_instr,      NOP);
    check("t6_rst_valid", 32'(if_id_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    run_to(1);
    check("t6_req",       32'(imem_req),    32'd1);
    check("t6_addr",      imem_addr,        32'h0);
    check("t6_ign_valid", 32'(if_id_valid), 32'd0);
    run_to(2);
    check("t6_ign_valid2", 32'(if_id_valid), 32'd0);
    check("t6_ign_instr",  if_id_instr,      NOP);
    run_to(6);
    check("t6_pc0",    if_id_pc,         32'h0);
    check("t6_instr0", if_id_instr,      32'h00C0_2083);
    check("t6_valid0", 32'(if_id_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
